// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a UART transmit engine through per-requester FIFOs.
// Latency: a byte pushed into an empty FIFO is loaded one edge later, with WRITES high the cycle after that.
// Backpressure: pushes to a full FIFO are dropped and flagged sticky; loads wait for TXRDY after a guard cycle.

// Small per-requester FIFO with a count-derived full/empty and a sticky overflow flag.
module uart_tx_arbiter_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO rejects the write even when a pop frees a slot on the same edge.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// Round-robin arbiter with a LOAD/GUARD/WAIT handshake towards the transmit engine.
// Latency: IDLE samples a non-empty FIFO with TXRDY high and enters LOAD on the next edge.
// Backpressure: stays in WAIT while TXRDY is low; pushes keep being accepted in all states.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_wr,
    input  logic [7:0] req0_data,
    output logic       req0_full,
    output logic       req0_ovf,
    input  logic       req1_wr,
    input  logic [7:0] req1_data,
    output logic       req1_full,
    output logic       req1_ovf,
    input  logic       TXRDY,
    output logic       WRITES,
    output logic [7:0] out_port,
    output logic       grant,
    output logic       busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] head0;
    logic [7:0] head1;
    logic       empty0;
    logic       empty1;
    logic       sel;
    logic       start;
    logic       pop0;
    logic       pop1;

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (req0_wr),
        .din   (req0_data),
        .pop   (pop0),
        .head  (head0),
        .full  (req0_full),
        .empty (empty0),
        .ovf   (req0_ovf)
    );

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (req1_wr),
        .din   (req1_data),
        .pop   (pop1),
        .head  (head1),
        .full  (req1_full),
        .empty (empty1),
        .ovf   (req1_ovf)
    );

    // WRITES comes straight from the state so reset kills it within the cycle.
    assign WRITES = (state == S_LOAD);
    assign busy   = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration choice and FIFO pops.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        // On a tie serve the requester that did not get the previous load.
        sel       = (!empty0 && !empty1) ? ~grant : !empty1;
        case (state)
            S_IDLE: begin
                if (TXRDY && (!empty0 || !empty1)) begin
                    start     = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_GUARD;
            // GUARD ignores TXRDY: the engine needs a cycle to drop ready.
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (TXRDY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        pop0 = start && !sel;
        pop1 = start && sel;
    end

    // Capture the served byte and requester only on the IDLE->LOAD edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port <= 8'h00;
            grant    <= 1'b1;
        end else if (start) begin
            out_port <= sel ? head1 : head0;
            grant    <= sel;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter with a transaction-level reference model.
// The model holds byte queues per requester and a "transmitter free" timeline; a monitor scores outputs.
// Every expected load is queued on issue and popped whenever the DUT pulses WRITES.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_wr;
    logic [7:0] req0_data;
    logic       req0_full;
    logic       req0_ovf;
    logic       req1_wr;
    logic [7:0] req1_data;
    logic       req1_full;
    logic       req1_ovf;
    logic       TXRDY;
    logic       WRITES;
    logic [7:0] out_port;
    logic       grant;
    logic       busy;

    uart_tx_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_wr   (req0_wr),
        .req0_data (req0_data),
        .req0_full (req0_full),
        .req0_ovf  (req0_ovf),
        .req1_wr   (req1_wr),
        .req1_data (req1_data),
        .req1_full (req1_full),
        .req1_ovf  (req1_ovf),
        .TXRDY     (TXRDY),
        .WRITES    (WRITES),
        .out_port  (out_port),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic [8:0] expq[$];
    bit         m_free;     // transmitter path ready to start a new load
    int         m_since;    // edges since the last load started
    bit         m_load;     // a load started at the most recent edge
    bit         m_grant;
    logic [7:0] m_out;
    bit         m_ovf0;
    bit         m_ovf1;
    bit         full0_pre;
    bit         full1_pre;
    bit         m_sel;
    logic [7:0] m_byte;

    // Model: one load per free slot; after a load the path needs LOAD, GUARD and
    // then a cycle of TXRDY (no earlier than the third edge) before it is free again.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            expq.delete();
            m_free  = 1'b1;
            m_since = 0;
            m_load  = 1'b0;
            m_grant = 1'b1;
            m_out   = 8'h00;
            m_ovf0  = 1'b0;
            m_ovf1  = 1'b0;
        end else begin
            full0_pre = (mq0.size() >= 4);
            full1_pre = (mq1.size() >= 4);
            m_load    = 1'b0;
            if (m_free) begin
                if (TXRDY && (mq0.size() > 0 || mq1.size() > 0)) begin
                    if (mq0.size() > 0 && mq1.size() > 0) m_sel = !m_grant;
                    else m_sel = (mq1.size() > 0);
                    m_byte  = m_sel ? mq1.pop_front() : mq0.pop_front();
                    m_out   = m_byte;
                    m_grant = m_sel;
                    expq.push_back({m_sel, m_byte});
                    m_free  = 1'b0;
                    m_since = 0;
                    m_load  = 1'b1;
                end
            end else begin
                m_since++;
                if (m_since >= 3 && TXRDY) m_free = 1'b1;
            end
            if (req0_wr) begin
                if (!full0_pre) mq0.push_back(req0_data);
                else m_ovf0 = 1'b1;
            end
            if (req1_wr) begin
                if (!full1_pre) mq1.push_back(req1_data);
                else m_ovf1 = 1'b1;
            end
        end
    end

    // Monitor: compare every cycle on the falling edge; score loads against the queue.
    logic       prev_writes = 1'b0;
    logic [8:0] e;
    always @(negedge clk) begin
        check("writes", WRITES, m_load);
        check("busy", busy, !m_free);
        check("grant", grant, m_grant);
        check("out_port", out_port, m_out);
        check("req0_full", req0_full, mq0.size() == 4);
        check("req1_full", req1_full, mq1.size() == 4);
        check("req0_ovf", req0_ovf, m_ovf0);
        check("req1_ovf", req1_ovf, m_ovf1);
        if (WRITES) begin
            check("writes_back_to_back", prev_writes, 1'b0);
            if (expq.size() == 0) begin
                check("sb_unexpected_load", 1, 0);
            end else begin
                e = expq.pop_front();
                check("sb_byte", out_port, e[7:0]);
                check("sb_grant", grant, e[8]);
            end
        end
        prev_writes = WRITES;
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input bit w0, input logic [7:0] d0, input bit w1, input logic [7:0] d1, input bit tr);
        req0_wr   = w0;
        req0_data = d0;
        req1_wr   = w1;
        req1_data = d1;
        TXRDY     = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit tr);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 8'h00, tr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 0);
        rst = 1'b0;
    endtask

    int found;

    initial begin
        rst = 1'b1;
        req0_wr = 0; req0_data = 0; req1_wr = 0; req1_data = 0; TXRDY = 0;
        #2;
        check("rst_writes", WRITES, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 1);
        check("rst_out", out_port, 8'h00);
        @(posedge clk); #1;
        do_reset();

        // Single byte from requester 0.
        cyc(1, 8'hA5, 0, 8'h00, 1);
        idle(8, 1);

        // Tie from reset: requester 0 wins first, then alternate.
        do_reset();
        cyc(1, 8'h11, 1, 8'h33, 0);
        cyc(1, 8'h22, 1, 8'h44, 0);
        idle(24, 1);

        // Overflow on requester 1 while the transmitter is busy.
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(0, 8'h00, 1, 8'(8'h50 + i), 0);
        idle(30, 1);

        // Backpressure: long TXRDY low after a load, with a byte waiting.
        cyc(1, 8'h61, 0, 8'h00, 1);
        cyc(0, 8'h00, 0, 8'h00, 1);
        cyc(1, 8'h62, 0, 8'h00, 0);
        idle(50, 0);
        idle(10, 1);

        // Push and pop on the same edge with two bytes queued.
        cyc(1, 8'h71, 0, 8'h00, 0);
        cyc(1, 8'h72, 0, 8'h00, 0);
        cyc(1, 8'h73, 0, 8'h00, 1);
        idle(20, 1);

        // Reset in the middle of a LOAD with three bytes queued.
        cyc(1, 8'h81, 0, 8'h00, 0);
        cyc(1, 8'h82, 0, 8'h00, 0);
        cyc(1, 8'h83, 0, 8'h00, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (WRITES) found = 1;
            else cyc(0, 8'h00, 0, 8'h00, 1);
        end
        check("load_reached", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_writes", WRITES, 0);
        check("rstmid_out", out_port, 8'h00);
        check("rstmid_full0", req0_full, 0);
        check("rstmid_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10, 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 4) != 0);
        end
        idle(40, 1);

        check("sb_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
